// File: rtl/sram_responder.sv
// sram_responder
//   Behavioural stand-in for an asynchronous SRAM chip as seen by a CPU's
//   MAR/MDR datapath. It holds a 1024 x 16 array that is written byte by byte
//   and read a full word at a time, with a small controller that decodes the
//   active-low SRAM strobes.
//
//   After reset the array is swept to zero, one word per cycle. Ready stays
//   low during the sweep, and all strobes are ignored until it completes.
//
//   A read returns data one cycle after OE is first seen low. A write commits
//   on the second WE-low edge. Strobe misuse sets sticky error flags.
//
// Ports
//   Clk            in   1  system clock, rising edge
//   Reset          in   1  synchronous active-high reset
//   Mem_CE         in   1  chip enable, active low
//   Mem_OE         in   1  read enable, active low
//   Mem_WE         in   1  write enable, active low
//   Mem_UB         in   1  upper byte (15:8) enable, active low
//   Mem_LB         in   1  lower byte (7:0) enable, active low
//   ADDR           in  20  word address; only the low 10 bits are backed by storage
//   Data_from_CPU  in  16  write data
//   Data_to_CPU    out 16  registered read data
//   Data_valid     out  1  Data_to_CPU holds data for the current read
//   Ready          out  1  initialisation finished
//   Err_flags      out  3  sticky: [0] OE/WE conflict, [1] short write, [2] out of range
module sram_responder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic        Ready,
  output logic [2:0]  Err_flags
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WR1,
    S_WR_HOLD
  } state_t;

  state_t      state_reg;
  logic [9:0]  init_cnt_reg;
  logic        data_valid_reg;
  logic        ready_reg;
  logic [2:0]  err_reg;

  // Active-high views of the strobes keep the decode readable.
  logic ce_act, oe_act, we_act;
  logic addr_in_range;
  logic conflict;
  logic rd_take;
  logic commit;
  logic [1:0]  byte_n;
  logic [1:0]  lane_we;
  logic [9:0]  wr_idx;
  logic [15:0] wr_data;

  assign ce_act        = ~Mem_CE;
  assign oe_act        = ~Mem_OE;
  assign we_act        = ~Mem_WE;
  assign addr_in_range = (ADDR[19:10] == 10'd0);
  assign byte_n        = {Mem_UB, Mem_LB};

  // OE and WE both low is illegal wherever a new access could start or a
  // write could still commit. Once a write has committed (WR_HOLD), the
  // write is already complete, so the conflict no longer applies there.
  assign conflict = ce_act && oe_act && we_act &&
                    ((state_reg == S_IDLE) || (state_reg == S_RD) || (state_reg == S_WR1));

  // A read loads the output register on the IDLE->RD edge and on every RD
  // edge that still has OE low.
  assign rd_take = !Reset && ce_act && oe_act && !we_act &&
                   ((state_reg == S_IDLE) || (state_reg == S_RD));

  // A write commits only on the WR1 edge that still has WE low. The second
  // WE-low edge is the only commit point, so a held strobe writes once.
  assign commit = !Reset && ce_act && we_act && !oe_act && (state_reg == S_WR1);

  // The write port is shared between the INIT sweep and CPU commits.
  // Holding Reset blocks any pending commit.
  assign wr_idx  = (state_reg == S_INIT) ? init_cnt_reg : ADDR[9:0];
  assign wr_data = (state_reg == S_INIT) ? 16'h0000 : Data_from_CPU;

  // Two independent byte lanes give per-byte write enables; reads take
  // both lanes together, so UB/LB never affect read data.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [1024];
      logic [7:0] rd_reg;

      assign lane_we[gi] = !Reset &&
                           ((state_reg == S_INIT) ||
                            (commit && addr_in_range && !byte_n[gi]));

      always_ff @(posedge Clk) begin
        if (lane_we[gi]) begin
          mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
      end

      // Out-of-range reads return zero instead of aliasing into the array.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          rd_reg <= 8'h00;
        end else if (rd_take) begin
          rd_reg <= addr_in_range ? mem[ADDR[9:0]] : 8'h00;
        end
      end

      assign Data_to_CPU[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  // Controller. Ready, Data_valid and Err_flags are all registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= S_INIT;
      init_cnt_reg   <= 10'd0;
      data_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      err_reg        <= 3'b000;
    end else begin
      case (state_reg)
        S_INIT: begin
          init_cnt_reg <= init_cnt_reg + 10'd1;
          if (init_cnt_reg == 10'd1023) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          if (!ce_act) begin
            // Chip deselect aborts whatever was in progress.
            state_reg      <= S_IDLE;
            data_valid_reg <= 1'b0;
          end else if (conflict) begin
            err_reg[0]     <= 1'b1;
            state_reg      <= S_IDLE;
            data_valid_reg <= 1'b0;
          end else begin
            case (state_reg)
              S_IDLE: begin
                if (oe_act) begin
                  state_reg      <= S_RD;
                  data_valid_reg <= 1'b1;
                  if (!addr_in_range) err_reg[2] <= 1'b1;
                end else if (we_act) begin
                  state_reg <= S_WR1;
                end
              end

              S_RD: begin
                if (oe_act) begin
                  data_valid_reg <= 1'b1;
                  if (!addr_in_range) err_reg[2] <= 1'b1;
                end else begin
                  state_reg      <= S_IDLE;
                  data_valid_reg <= 1'b0;
                end
              end

              S_WR1: begin
                if (we_act) begin
                  state_reg <= S_WR_HOLD;
                  if (!addr_in_range) err_reg[2] <= 1'b1;
                end else begin
                  // WE released after one edge: too short to be a write.
                  err_reg[1] <= 1'b1;
                  state_reg  <= S_IDLE;
                end
              end

              S_WR_HOLD: begin
                if (!we_act) state_reg <= S_IDLE;
              end

              default: begin
                state_reg      <= S_IDLE;
                data_valid_reg <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign Data_valid = data_valid_reg;
  assign Ready      = ready_reg;
  assign Err_flags  = err_reg;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Self-checking bench for sram_responder. Bus transactions (read, write
//   with a chosen WE-low length, OE/WE conflict, deselect abort, reset
//   mid-write) are checked against a word-level memory model with sticky
//   error flags. Directed cases come first, followed by randomized traffic.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [19:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Data_valid;
  logic        Ready;
  logic [2:0]  Err_flags;

  sram_responder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_CE        (Mem_CE),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .Mem_UB        (Mem_UB),
    .Mem_LB        (Mem_LB),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Data_valid    (Data_valid),
    .Ready         (Ready),
    .Err_flags     (Err_flags)
  );

  always #5 Clk = ~Clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: word contents, sticky error flags, and the last value
  // the read register should hold.
  logic [15:0] ref_mem [1024];
  logic [2:0]  ref_err;
  logic [15:0] ref_dout;
  logic [15:0] last_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus();
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
    ref_err  = 3'b000;
    ref_dout = 16'h0000;
  endtask

  function automatic logic [15:0] ref_word(input logic [19:0] a);
    return (a[19:10] == 10'd0) ? ref_mem[a[9:0]] : 16'h0000;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!Ready && n < 2000) begin
      tick();
      n++;
    end
    check_val("ready_latency", n, 1024);
  endtask

  task automatic do_reset_and_init();
    Reset = 1'b1;
    idle_bus();
    ADDR = 20'h0; Data_from_CPU = 16'h0;
    tick(); tick();
    check_val("rst_ready", Ready, 0);
    check_val("rst_valid", Data_valid, 0);
    check_val("rst_dout", Data_to_CPU, 0);
    check_val("rst_err", Err_flags, 0);
    Reset = 1'b0;
    wait_ready();
    ref_clear();
    $display("reset+init done, Ready=%0b", Ready);
  endtask

  // OE low for two edges, first at addr then at addr2, then OE released.
  task automatic do_read(input logic [19:0] addr, input logic [19:0] addr2);
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = addr;
    tick();
    ref_dout = ref_word(addr);
    if (addr[19:10] != 10'd0) ref_err[2] = 1'b1;
    check_val("rd_valid1", Data_valid, 1);
    check_val("rd_data1", Data_to_CPU, ref_dout);
    check_val("rd_err1", Err_flags, ref_err);
    ADDR = addr2;
    tick();
    ref_dout = ref_word(addr2);
    if (addr2[19:10] != 10'd0) ref_err[2] = 1'b1;
    check_val("rd_valid2", Data_valid, 1);
    check_val("rd_data2", Data_to_CPU, ref_dout);
    last_rd = Data_to_CPU;
    Mem_OE = 1'b1;
    tick();
    check_val("rd_end_valid", Data_valid, 0);
    check_val("rd_end_hold", Data_to_CPU, ref_dout);
    idle_bus();
    tick();
    $display("read  a=%05h a2=%05h data=%04h err=%03b", addr, addr2, last_rd, Err_flags);
  endtask

  // WE low for ncyc edges; data switches to alt after the commit edge.
  task automatic do_write(input logic [19:0] addr, input logic [15:0] data,
                          input logic ub, input logic lb, input int ncyc,
                          input logic [15:0] alt);
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = ub; Mem_LB = lb;
    ADDR = addr; Data_from_CPU = data;
    tick();
    for (int k = 1; k < ncyc; k++) begin
      tick();
      Data_from_CPU = alt;
    end
    Mem_WE = 1'b1;
    tick();
    idle_bus();
    tick();
    if (ncyc < 2) ref_err[1] = 1'b1;
    else if (addr[19:10] != 10'd0) ref_err[2] = 1'b1;
    else begin
      if (!ub) ref_mem[addr[9:0]][15:8] = data[15:8];
      if (!lb) ref_mem[addr[9:0]][7:0]  = data[7:0];
    end
    check_val("wr_err", Err_flags, ref_err);
    check_val("wr_valid", Data_valid, 0);
    $display("write a=%05h d=%04h ub=%0b lb=%0b cyc=%0d err=%03b", addr, data, ub, lb, ncyc, Err_flags);
  endtask

  task automatic do_conflict(input logic [19:0] addr, input logic [15:0] data);
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = addr; Data_from_CPU = data;
    tick();
    ref_err[0] = 1'b1;
    check_val("cf_err", Err_flags, ref_err);
    check_val("cf_valid", Data_valid, 0);
    idle_bus();
    tick();
    $display("conflict a=%05h err=%03b", addr, Err_flags);
  endtask

  task automatic do_abort_read(input logic [19:0] addr);
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = addr;
    tick();
    ref_dout = ref_word(addr);
    if (addr[19:10] != 10'd0) ref_err[2] = 1'b1;
    check_val("ab_data", Data_to_CPU, ref_dout);
    Mem_CE = 1'b1;
    tick();
    check_val("ab_valid", Data_valid, 0);
    check_val("ab_hold", Data_to_CPU, ref_dout);
    idle_bus();
    $display("abort read a=%05h", addr);
  endtask

  function automatic logic [19:0] rand_addr();
    int r = $urandom_range(0, 19);
    logic [19:0] a;
    if (r == 0) begin
      a[19:10] = 10'($urandom_range(1, 1023));
      a[9:0]   = 10'($urandom_range(0, 1023));
    end else if (r == 1) begin
      a = 20'h003FF;
    end else begin
      a = 20'($urandom_range(0, 31));
    end
    return a;
  endfunction

  initial begin
    idle_bus();
    Reset = 1'b1;
    ADDR = 20'h0;
    Data_from_CPU = 16'h0;
    last_rd = 16'h0;
    do_reset_and_init();

    // Freshly initialised words read as zero.
    do_read(20'h003FF, 20'h00000);
    check_val("init_zero", last_rd, 16'h0000);

    do_write(20'h00012, 16'hBEEF, 1'b0, 1'b0, 2, 16'hBEEF);
    do_read(20'h00012, 20'h00012);
    check_val("beef", last_rd, 16'hBEEF);

    do_write(20'h00012, 16'h1234, 1'b1, 1'b0, 2, 16'h1234);
    do_read(20'h00012, 20'h00012);
    check_val("byte_lo", last_rd, 16'hBE34);

    do_write(20'h00012, 16'hAAAA, 1'b0, 1'b0, 1, 16'hAAAA);
    check_val("short_err", Err_flags, 3'b010);
    do_read(20'h00012, 20'h00012);
    check_val("short_nowr", last_rd, 16'hBE34);

    do_write(20'h00020, 16'h5555, 1'b0, 1'b0, 5, 16'h6666);
    do_read(20'h00020, 20'h00020);
    check_val("hold_once", last_rd, 16'h5555);

    do_conflict(20'h00020, 16'h7777);
    check_val("cf_flag", Err_flags[0], 1);
    do_read(20'h00020, 20'h00400);
    check_val("oor_data", last_rd, 16'h0000);
    check_val("oor_err", Err_flags, 3'b111);

    // Reset while a write sits in WR1.
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 20'h00040; Data_from_CPU = 16'hCAFE;
    tick();
    Reset = 1'b1;
    tick();
    check_val("wr1rst_ready", Ready, 0);
    check_val("wr1rst_err", Err_flags, 0);
    Reset = 1'b0;
    idle_bus();
    wait_ready();
    ref_clear();
    do_read(20'h00040, 20'h00040);
    check_val("wr1rst_data", last_rd, 16'h0000);
    check_val("wr1rst_err2", Err_flags, 3'b000);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 4) begin
        do_write(rand_addr(), 16'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 5)),
                 16'($urandom));
      end else if (kind < 8) begin
        do_read(rand_addr(), rand_addr());
      end else if (kind == 8) begin
        do_conflict(rand_addr(), 16'($urandom));
      end else begin
        do_abort_read(rand_addr());
      end
    end

    // Sweep the hot region to catch any stray write.
    for (int a = 0; a < 32; a += 2) do_read(20'(a), 20'(a + 1));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL use one clock and a reset that is synchronous and active-high; ports are named Clk and Reset.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Mem_CE  input  1  chip enable, active low.
REQ-005 Mem_OE  input  1  output (read) enable, active low.
REQ-006 Mem_WE  input  1  write enable, active low.
REQ-007 Mem_UB  input  1  upper-byte enable (bits 15:8), active low.
REQ-008 Mem_LB  input  1  lower-byte enable (bits 7:0), active low.
REQ-009 ADDR  input  20  word address from MAR.
REQ-010 Data_from_CPU  input  16  write data from MDR.
REQ-011 Data_to_CPU  output  16  registered read data.
REQ-012 Data_valid  output  1  Data_to_CPU holds data for the current read.
REQ-013 Ready  output  1  array initialised; strobes are honoured.
REQ-014 Err_flags  output  3  sticky errors: [0] OE/WE conflict, [1] short write strobe, [2] address out of range.

Function
REQ-015 SHALL hold a 1024 x 16 array indexed by ADDR[9:0]; ADDR[19:10] != 0 is out of range.
REQ-016 SHALL implement states INIT, IDLE, RD, WR1, WR_HOLD.
REQ-017 INIT: write 16'h0000 to word index counter (0..1023), one word per cycle; counter 1023 -> IDLE; all strobes ignored; Ready=0.
REQ-018 Ready SHALL be 1 in every state except INIT.
REQ-019 In any non-INIT state, Mem_CE=1 SHALL return to IDLE next edge, with no array write and Data_valid cleared.
REQ-020 IDLE, CE=0, OE=0, WE=1: Data_to_CPU <= array[ADDR] (16'h0000 if out of range, setting Err_flags[2]); go to RD.
REQ-021 Read latency SHALL be one cycle: data valid during the second OE-low cycle so the MDR load at the end of that cycle captures it.
REQ-022 RD, OE still 0: refresh Data_to_CPU from current ADDR each edge; Data_valid=1; stay in RD.
REQ-023 RD, OE=1: go to IDLE, clear Data_valid; Data_to_CPU keeps its last value.
REQ-024 IDLE, CE=0, WE=0, OE=1: go to WR1; no array write yet.
REQ-025 WR1, WE still 0: commit Data_from_CPU to array[ADDR] at that edge, writing only bytes whose UB/LB is 0; go to WR_HOLD.
REQ-026 WR1, WE=1: drop the write, set Err_flags[1], go to IDLE.
REQ-027 WR_HOLD: no further commits while WE=0; WE=1 -> IDLE. A held strobe yields exactly one write.
REQ-028 Out-of-range commit SHALL NOT modify the array and SHALL set Err_flags[2].
REQ-029 OE=0 and WE=0 together with CE=0, sampled in IDLE, RD or WR1: no access, set Err_flags[0], go to IDLE, clear Data_valid.
REQ-030 Err_flags bits SHALL be sticky until Reset.
REQ-031 Reads SHALL ignore UB/LB and always return the full word.
REQ-032 Write then read of the same address SHALL return the new data; there is no read-during-write bypass because the states are exclusive.

Reset
REQ-033 Reset SHALL take effect at the next edge from any state: state=INIT, counter=0, Data_to_CPU=16'h0000, Data_valid=0, Ready=0, Err_flags=3'b000.
REQ-034 Reset during WR1 or WR_HOLD SHALL NOT commit the pending write; the array is then re-cleared by INIT.

Verification
REQ-035 Reset released -> Ready=0 for exactly 1024 cycles, then 1; a read of any address returns 16'h0000.
REQ-036 WE low for 2 cycles, ADDR=20'h00012, data 16'hBEEF, UB=LB=0; then OE low for 2 cycles -> Data_valid=1 and Data_to_CPU=16'hBEEF in the second OE cycle.
REQ-037 Write 16'h1234 with UB=1, LB=0 to a word holding 16'hBEEF -> read returns 16'hBE34.
REQ-038 WE low for 1 cycle only -> no array change, Err_flags=3'b010; WE held low for 5 cycles -> exactly one write.
REQ-039 OE and WE low together -> Err_flags[0]=1, no write; read of ADDR=20'h00400 -> 16'h0000 and Err_flags[2]=1.
REQ-040 Reset asserted during WR1 -> the word is not written; after INIT completes, the read returns 16'h0000 and Err_flags=3'b000.
